cs0_mem_arbiter: RTL and testbench
==================================

Name: cs0_mem_arbiter

Overview:
Shares one external memory port (SDRAM-backed BIOS/LWRAM/backup image) between the CS0 CPU bus and a host/backup-save requester.
- Detects CPU read/write strobes and captures the access.
- Holds the CPU with WAIT_N until the memory completes the access.
- Interleaves host accesses with a starvation guard.
- Sits behind the CS0 decode/wait-state logic. Its WAIT_N is ANDed into the bus wait.

Parameters:
AW, 20, word-address width of memory port.
HOST_STARVE, 8, CPU-won arbitration rounds after which a pending host request is forced to win.
TIMEOUT, 64, cycles allowed for MEM_RDY before an access is aborted.

Ports:
CLK  in  1  system clock; the only clock
RST  in  1  reset; synchronous, active-high
CPU_SEL  in  1  CS0 memory region decoded (active-high)
CPU_A  in  AW  CPU word address
CPU_D  in  16  CPU write data
CPU_RD_N  in  1  CPU read strobe
CPU_WE_N  in  2  CPU byte write strobes, [1]=high byte
CPU_Q  out  16  CPU read data, held until next CPU read completes
CPU_WAIT_N  out  1  low = stall CPU
HOST_REQ  in  1  host access request, level; held until HOST_ACK
HOST_WE  in  1  1=write, 0=read
HOST_A  in  AW  host address
HOST_D  in  16  host write data
HOST_Q  out  16  host read data, valid with HOST_ACK
HOST_ACK  out  1  one-cycle completion pulse
MEM_REQ  out  1  memory request, held until MEM_RDY
MEM_A  out  AW  memory address
MEM_D  out  16  memory write data
MEM_WE  out  1  write enable
MEM_BE  out  2  byte enables
MEM_Q  in  16  memory read data, valid with MEM_RDY
MEM_RDY  in  1  one-cycle completion pulse
ERR  out  1  sticky timeout flag; cleared only by RST

Behaviour:
- Reset values: all outputs 0 except CPU_WAIT_N=1. Registers: state=IDLE, cpu_pend=0, starve=0, tcnt=0, RD_N_OLD=1, WE_N_OLD=1.
- Reset mid-access: MEM_REQ drops the cycle after RST. The in-flight access is discarded. No ACK is issued.
- CPU start event (start): CPU_SEL & ((!CPU_RD_N & RD_N_OLD) | (!(&CPU_WE_N) & WE_N_OLD)).
  - On start, register A, D, RD/WE and BE = ~CPU_WE_N. For reads, BE = 2'b11.
  - Set cpu_pend.
- CPU_WAIT_N = ~(start | cpu_pend | state==CPU_ACC). It is combinational so the stall asserts in the same cycle as the strobe edge.
- A second CPU start while cpu_pend=1 is a protocol violation and is ignored. The CPU cannot issue one while stalled.
- FSM states: IDLE, CPU_ACC, HOST_ACC, HOST_DONE.
- IDLE arbitration:
  - Only cpu_pend → CPU_ACC. If HOST_REQ was also pending, starve++ (saturating at HOST_STARVE).
  - Only HOST_REQ → HOST_ACC.
  - Both pending: HOST_ACC if starve>=HOST_STARVE, else CPU_ACC.
  - Entering HOST_ACC clears starve.
  - A start in the same cycle as IDLE counts as pending from the next cycle. No bypass.
- On entry to CPU_ACC or HOST_ACC:
  - MEM_REQ=1 with MEM_A/D/WE/BE driven from the winner's captured fields.
  - MEM_REQ asserts 1 cycle after the IDLE decision.
  - tcnt=0.
- CPU_ACC:
  - On MEM_RDY: CPU_Q<=MEM_Q if read; cpu_pend<=0; MEM_REQ<=0; go to IDLE.
  - CPU_WAIT_N is high from the next cycle.
- HOST_ACC:
  - On MEM_RDY: HOST_Q<=MEM_Q if read; MEM_REQ<=0; go to HOST_DONE.
  - HOST_DONE pulses HOST_ACK for 1 cycle, then returns to IDLE. This gives the host one cycle to drop HOST_REQ.
- Timeout: tcnt increments every cycle in the *_ACC states. When tcnt==TIMEOUT-1 without MEM_RDY:
  - Abort and set ERR.
  - Return read data 16'hFFFF.
  - Complete the transaction exactly as if MEM_RDY had arrived.
- MEM_RDY outside CPU_ACC/HOST_ACC is ignored.
- MEM_RDY in the same cycle as the timeout is treated as success: ERR is not set and MEM_Q is used.
- Host write BE is 2'b11.
- The only arithmetic is the saturating counters: starve is width $clog2(HOST_STARVE+1), tcnt is width $clog2(TIMEOUT).

Decomposition:
- Shared package cs0_mem_pkg holds:
  - the state enum;
  - the access-descriptor struct {a, d, we, be};
  - the READ_FILL=16'hFFFF constant.
- One natural sub-module: cs0_strobe_capture. It does the edge detect, capture register and cpu_pend, and drives the start output.

Test Plan:
- CPU read, A=0x00100, MEM_RDY 5 cycles after MEM_REQ, MEM_Q=0x1234 → WAIT_N low from strobe cycle through the RDY cycle, CPU_Q=0x1234, MEM_BE=11.
- CPU byte write, CPU_WE_N=2'b10, D=0xABCD → MEM_WE=1, MEM_BE=2'b01, MEM_D=0xABCD, no HOST_ACK.
- HOST_REQ held while the CPU issues 8 back-to-back reads → first 8 rounds CPU, 9th round host, HOST_ACK pulse with HOST_Q=MEM_Q, starve reset to 0.
- Simultaneous host request and CPU start in IDLE with starve=0 → CPU served first, host next; the CPU stall never exceeds one host access plus its own.
- MEM_RDY never asserted on a CPU read → abort after 64 cycles, CPU_Q=0xFFFF, ERR=1, WAIT_N released; ERR stays 1 until RST.
- RST asserted 2 cycles into a host access → MEM_REQ=0 and CPU_WAIT_N=1 next cycle, no HOST_ACK; a late MEM_RDY is ignored.

Source files
------------

// File: rtl/cs0_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs0_mem_pkg
// Purpose  : Shared types and constants for the CS0 memory-port arbiter.
//            Arbiter state encoding, the access descriptor that carries one
//            captured memory transaction, and the read fill value returned
//            when an access is aborted.
// Revision : 1.0  initial release
// ============================================================================
package cs0_mem_pkg;

  // Widest memory word address a descriptor can carry. Instances narrower
  // than this zero-extend into the descriptor and slice back out.
  localparam int ADDR_MAX = 32;

  // Data handed back to a reader whose access timed out.
  localparam logic [15:0] READ_FILL = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CPU_ACC   = 2'd1,
    ST_HOST_ACC  = 2'd2,
    ST_HOST_DONE = 2'd3
  } state_t;

  // One memory transaction: address, write data, direction and byte lanes.
  typedef struct packed {
    logic [ADDR_MAX-1:0] a;
    logic [15:0]         d;
    logic                we;
    logic [1:0]          be;
  } access_t;

  // Read data to capture on completion: memory data, or the fill on abort.
  function automatic logic [15:0] rd_or_fill(input logic abort, input logic [15:0] q);
    return abort ? READ_FILL : q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cs0_mem_arbiter_strobe_capture.sv
`default_nettype none
// ============================================================================
// Module   : cs0_strobe_capture
// Purpose  : Detects CPU read/write strobe falling edges inside the CS0
//            region, captures the access fields and holds the pending flag
//            until the arbiter completes the CPU access.
// Revision : 1.0  initial release
// ============================================================================
module cs0_strobe_capture #(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_sel,
  input  logic [AW-1:0] cpu_a,
  input  logic [15:0]   cpu_d,
  input  logic          cpu_rd_n,
  input  logic [1:0]    cpu_we_n,
  input  logic          clr,
  output logic          start,
  output logic          pend,
  output logic [AW-1:0] cap_a,
  output logic [15:0]   cap_d,
  output logic          cap_we,
  output logic [1:0]    cap_be
);

  logic rd_n_old;
  logic we_n_old;
  logic rd_fall;
  logic we_fall;
  logic is_wr;

  // A strobe only counts on its falling edge; a held strobe never retriggers.
  assign rd_fall = ~cpu_rd_n & rd_n_old;
  assign we_fall = ~(&cpu_we_n) & we_n_old;
  assign start   = cpu_sel & (rd_fall | we_fall);
  assign is_wr   = ~(&cpu_we_n);

  // Edge history, pending flag and capture register for the CPU access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_n_old <= 1'b1;
      we_n_old <= 1'b1;
      pend     <= 1'b0;
      cap_a    <= '0;
      cap_d    <= '0;
      cap_we   <= 1'b0;
      cap_be   <= 2'b00;
    end else begin
      rd_n_old <= cpu_rd_n;
      we_n_old <= &cpu_we_n;
      if (clr) begin
        pend <= 1'b0;
      end else if (start) begin
        pend <= 1'b1;
      end
      // A start while one is already pending would overwrite a live access,
      // so it is dropped rather than captured.
      if (start && !pend) begin
        cap_a  <= cpu_a;
        cap_d  <= cpu_d;
        cap_we <= is_wr;
        cap_be <= is_wr ? ~cpu_we_n : 2'b11;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cs0_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cs0_mem_arbiter
// Purpose  : Shares one external memory port between the CS0 CPU bus and a
//            host/backup-save requester. Stalls the CPU with cpu_wait_n while
//            its access is outstanding, interleaves host accesses under a
//            starvation guard and aborts accesses that never see mem_rdy.
// Revision : 1.0  initial release
// ============================================================================
module cs0_mem_arbiter
  import cs0_mem_pkg::*;
#(
  parameter int AW          = 20,
  parameter int HOST_STARVE = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_sel,
  input  logic [AW-1:0] cpu_a,
  input  logic [15:0]   cpu_d,
  input  logic          cpu_rd_n,
  input  logic [1:0]    cpu_we_n,
  output logic [15:0]   cpu_q,
  output logic          cpu_wait_n,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_a,
  input  logic [15:0]   host_d,
  output logic [15:0]   host_q,
  output logic          host_ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_a,
  output logic [15:0]   mem_d,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  input  logic [15:0]   mem_q,
  input  logic          mem_rdy,
  output logic          err
);

  localparam int SW = $clog2(HOST_STARVE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_SAT = SW'(HOST_STARVE);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve;
  logic [TW-1:0] tcnt;

  logic          start;
  logic          cpu_pend;
  logic          cpu_clr;
  logic [AW-1:0] cap_a;
  logic [15:0]   cap_d;
  logic          cap_we;
  logic [1:0]    cap_be;

  access_t       cpu_acc;
  access_t       host_acc;
  access_t       win_acc;
  logic          unused_win_a;

  logic          go_cpu;
  logic          go_host;
  logic          acc_done;
  logic          acc_abort;
  logic          in_acc;

  cs0_strobe_capture #(
    .AW (AW)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .cpu_sel  (cpu_sel),
    .cpu_a    (cpu_a),
    .cpu_d    (cpu_d),
    .cpu_rd_n (cpu_rd_n),
    .cpu_we_n (cpu_we_n),
    .clr      (cpu_clr),
    .start    (start),
    .pend     (cpu_pend),
    .cap_a    (cap_a),
    .cap_d    (cap_d),
    .cap_we   (cap_we),
    .cap_be   (cap_be)
  );

  // Both requesters expressed as descriptors; the host always writes full words.
  assign cpu_acc  = '{a: ADDR_MAX'(cap_a),  d: cap_d,  we: cap_we,  be: cap_be};
  assign host_acc = '{a: ADDR_MAX'(host_a), d: host_d, we: host_we, be: 2'b11};
  assign win_acc  = go_host ? host_acc : cpu_acc;
  // Descriptor address bits above AW are always zero here.
  assign unused_win_a = &{1'b0, win_acc.a};

  assign in_acc  = (state == ST_CPU_ACC) || (state == ST_HOST_ACC);
  assign cpu_clr = (state == ST_CPU_ACC) && acc_done;

  // Combinational so the stall reaches the bus in the same cycle as the strobe.
  assign cpu_wait_n = ~(start | cpu_pend | (state == ST_CPU_ACC));
  assign host_ack   = (state == ST_HOST_DONE);

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, completion and timeout decisions.
  always_comb begin
    state_nxt = state;
    go_cpu    = 1'b0;
    go_host   = 1'b0;
    acc_done  = 1'b0;
    acc_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_pend && host_req) begin
          if (starve >= STARVE_SAT) begin
            go_host = 1'b1;
          end else begin
            go_cpu = 1'b1;
          end
        end else if (cpu_pend) begin
          go_cpu = 1'b1;
        end else if (host_req) begin
          go_host = 1'b1;
        end
        if (go_cpu) begin
          state_nxt = ST_CPU_ACC;
        end else if (go_host) begin
          state_nxt = ST_HOST_ACC;
        end
      end
      ST_CPU_ACC, ST_HOST_ACC: begin
        // A ready arriving on the last allowed cycle still wins over the abort.
        if (mem_rdy) begin
          acc_done = 1'b1;
        end else if (tcnt == TCNT_LAST) begin
          acc_done  = 1'b1;
          acc_abort = 1'b1;
        end
        if (acc_done) begin
          state_nxt = (state == ST_CPU_ACC) ? ST_IDLE : ST_HOST_DONE;
        end
      end
      ST_HOST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: CPU rounds won while the host was also waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (go_host) begin
      starve <= '0;
    end else if (go_cpu && host_req && (starve != STARVE_SAT)) begin
      starve <= starve + 1'b1;
    end
  end

  // Access-duration counter, restarted whenever an access is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (go_cpu || go_host) begin
      tcnt <= '0;
    end else if (in_acc) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Memory port: loaded from the winner on grant, request dropped on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req <= 1'b0;
      mem_a   <= '0;
      mem_d   <= '0;
      mem_we  <= 1'b0;
      mem_be  <= 2'b00;
    end else if (go_cpu || go_host) begin
      mem_req <= 1'b1;
      mem_a   <= win_acc.a[AW-1:0];
      mem_d   <= win_acc.d;
      mem_we  <= win_acc.we;
      mem_be  <= win_acc.be;
    end else if (acc_done) begin
      mem_req <= 1'b0;
    end
  end

  // Read-data return to the owner of the completing access, plus sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_q  <= '0;
      host_q <= '0;
      err    <= 1'b0;
    end else if (acc_done) begin
      if (acc_abort) begin
        err <= 1'b1;
      end
      if (!mem_we) begin
        if (state == ST_CPU_ACC) begin
          cpu_q <= rd_or_fill(acc_abort, mem_q);
        end else begin
          host_q <= rd_or_fill(acc_abort, mem_q);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cs0_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs0_mem_arbiter
// Purpose  : Self-checking bench for cs0_mem_arbiter. A memory responder
//            answers requests after a programmable latency; a reference
//            memory and a starvation-round counter predict read data,
//            grant order and CPU stall length.
// Revision : 1.0  initial release
// ============================================================================
module tb_cs0_mem_arbiter;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_sel;
  logic [AW-1:0] cpu_a;
  logic [15:0]   cpu_d;
  logic          cpu_rd_n;
  logic [1:0]    cpu_we_n;
  logic [15:0]   cpu_q;
  logic          cpu_wait_n;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_a;
  logic [15:0]   host_d;
  logic [15:0]   host_q;
  logic          host_ack;
  logic          mem_req;
  logic [AW-1:0] mem_a;
  logic [15:0]   mem_d;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [15:0]   mem_q;
  logic          mem_rdy;
  logic          err;

  always #5 clk = ~clk;

  cs0_mem_arbiter #(.AW(AW), .HOST_STARVE(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cpu_sel(cpu_sel), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_rd_n(cpu_rd_n),
    .cpu_we_n(cpu_we_n), .cpu_q(cpu_q), .cpu_wait_n(cpu_wait_n),
    .host_req(host_req), .host_we(host_we), .host_a(host_a), .host_d(host_d),
    .host_q(host_q), .host_ack(host_ack),
    .mem_req(mem_req), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
    .mem_be(mem_be), .mem_q(mem_q), .mem_rdy(mem_rdy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: env_mem is what the responder holds, ref_mem is what
  // the stimulus believes it wrote. Untouched words have a fixed pattern.
  logic [15:0] env_mem [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 953) ^ 16'hC35A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] env_rd(input int a);
    return env_mem.exists(a) ? env_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    int          a;
    logic [15:0] d;
    logic        we;
    logic [1:0]  be;
  } rec_t;
  rec_t served[$];

  int lat       = 0;
  bit no_rdy    = 1'b0;
  bit force_rdy = 1'b0;

  // Memory responder: answers lat cycles after the first request cycle.
  initial begin : responder
    int age;
    age     = 0;
    mem_rdy = 1'b0;
    mem_q   = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rdy = 1'b0;
      if (rst || !mem_req) begin
        age = 0;
      end else begin
        age++;
        if (!no_rdy && age == lat + 1) begin
          served.push_back('{a: int'(mem_a), d: mem_d, we: mem_we, be: mem_be});
          if (mem_we) env_mem[int'(mem_a)] = merge(env_rd(int'(mem_a)), mem_d, mem_be);
          else        mem_q = env_rd(int'(mem_a));
          mem_rdy = 1'b1;
        end
      end
      if (force_rdy) begin
        mem_q   = 16'hDEAD;
        mem_rdy = 1'b1;
      end
    end
  end

  int          acks = 0;
  logic [15:0] last_hq = '0;
  logic        first_wait;

  // One clock; the host drops its request as soon as it sees the ack.
  task automatic tick();
    @(posedge clk);
    #1;
    if (host_ack) begin
      acks++;
      last_hq  = host_q;
      host_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    served.delete();
  endtask

  // One CPU access; returns the number of cycles cpu_wait_n was low.
  task automatic cpu_access(input int a, input logic [15:0] d, input logic [1:0] we_n,
                            input bit raise_host, input bit withdraw, output int stall);
    cpu_sel = 1'b1;
    cpu_a   = AW'(a);
    cpu_d   = d;
    if (we_n == 2'b11) cpu_rd_n = 1'b0;
    else               cpu_we_n = we_n;
    #1;
    first_wait = cpu_wait_n;
    stall = 0;
    while (!cpu_wait_n && stall < 300) begin
      stall++;
      tick();
      if (stall == 1 && raise_host) host_req = 1'b1;
    end
    if (withdraw) host_req = 1'b0;
    cpu_sel  = 1'b0;
    cpu_rd_n = 1'b1;
    cpu_we_n = 2'b11;
    tick();
  endtask

  task automatic wait_ack(input int acks0);
    int n;
    n = 0;
    while (acks == acks0 && n < 300) begin
      n++;
      tick();
    end
    check("host_ack_seen", acks, acks0 + 1);
  endtask

  task automatic pop_check(input string tag, input int a, input logic we, input logic [1:0] be,
                           input bit chk_be);
    rec_t r;
    check({tag, "_present"}, served.size() > 0, 1);
    if (served.size() > 0) begin
      r = served.pop_front();
      check({tag, "_a"}, r.a, a);
      check({tag, "_we"}, r.we, we);
      if (chk_be) check({tag, "_be"}, r.be, be);
    end
  endtask

  initial begin : stimulus
    int st;
    int a;
    int acks0;
    int model_starve;
    logic [15:0] d;
    logic [1:0]  wn;
    logic [1:0]  wr_pat [3];
    bit cpu_first;

    rst = 1'b1; cpu_sel = 1'b0; cpu_a = '0; cpu_d = '0; cpu_rd_n = 1'b1; cpu_we_n = 2'b11;
    host_req = 1'b0; host_we = 1'b0; host_a = '0; host_d = '0;
    wr_pat[0] = 2'b10; wr_pat[1] = 2'b01; wr_pat[2] = 2'b00;
    do_reset();

    // Reset values
    check("rst_cpu_q", cpu_q, 0);
    check("rst_wait_n", cpu_wait_n, 1);
    check("rst_host_q", host_q, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_err", err, 0);

    // Directed CPU read, ready five cycles after the request
    env_mem[32'h100] = 16'h1234;
    ref_mem[32'h100] = 16'h1234;
    lat = 5;
    cpu_access(32'h100, 16'h0, 2'b11, 0, 0, st);
    check("rd_wait_at_strobe", first_wait, 0);
    check("rd_stall", st, 3 + lat);
    check("rd_cpu_q", cpu_q, 16'h1234);
    pop_check("rd", 32'h100, 1'b0, 2'b11, 1);

    // Directed low-byte write, then read it back
    a = 32'h123;
    lat = 2;
    acks0 = acks;
    cpu_access(a, 16'hABCD, 2'b10, 0, 0, st);
    check("bw_stall", st, 3 + lat);
    check("bw_no_ack", acks, acks0);
    check("bw_mem_d", served.size() > 0 ? served[0].d : 16'h0, 16'hABCD);
    pop_check("bw", a, 1'b1, 2'b01, 1);
    ref_mem[a] = merge(ref_rd(a), 16'hABCD, 2'b01);
    cpu_access(a, 16'h0, 2'b11, 0, 0, st);
    check("bw_readback", cpu_q, ref_rd(a));
    served.delete();

    // Host write then host read, CPU reads the host's word
    host_we = 1'b1; host_a = AW'(32'h80010); host_d = 16'h5AA5;
    acks0 = acks; host_req = 1'b1;
    wait_ack(acks0);
    ref_mem[32'h80010] = 16'h5AA5;
    host_we = 1'b0; host_a = AW'(32'h80011);
    acks0 = acks; host_req = 1'b1;
    wait_ack(acks0);
    check("host_rd_q", last_hq, ref_rd(32'h80011));
    tick();
    cpu_access(32'h80010, 16'h0, 2'b11, 0, 0, st);
    check("host_wr_readback", cpu_q, 16'h5AA5);
    served.delete();

    // Random CPU traffic against the reference memory
    for (int i = 0; i < 16; i++) begin
      a   = int'($urandom_range(0, 15));
      d   = 16'($urandom);
      wn  = ($urandom_range(0, 1) == 0) ? 2'b11 : wr_pat[$urandom_range(0, 2)];
      lat = int'($urandom_range(0, 5));
      cpu_access(a, d, wn, 0, 0, st);
      check("rnd_stall", st, 3 + lat);
      if (wn == 2'b11) begin
        check("rnd_rd_q", cpu_q, ref_rd(a));
        pop_check("rnd_rd", a, 1'b0, 2'b11, 1);
      end else begin
        check("rnd_wr_d", served.size() > 0 ? served[0].d : ~d, d);
        pop_check("rnd_wr", a, 1'b1, ~wn, 1);
        ref_mem[a] = merge(ref_rd(a), d, ~wn);
      end
    end

    // Starvation guard: host waits behind CPU rounds, withdrawn for the first 8
    do_reset();
    model_starve = 0;
    for (int i = 0; i < 10; i++) begin
      a   = 32'h40 + i;
      lat = int'($urandom_range(0, 4));
      host_we = 1'b0; host_a = AW'(32'h80100 + i);
      cpu_first = (model_starve < 8);
      acks0 = acks;
      cpu_access(a, 16'h0, 2'b11, 1, (i < 8), st);
      if (cpu_first) begin
        check("sv_stall_cpu_first", st, 3 + lat);
        model_starve = (model_starve < 8) ? model_starve + 1 : 8;
        if (i >= 8) wait_ack(acks0);
        pop_check("sv_cpu", a, 1'b0, 2'b11, 1);
        if (i >= 8) begin
          pop_check("sv_host_after", 32'h80100 + i, 1'b0, 2'b11, 0);
          check("sv_host_q_after", last_hq, ref_rd(32'h80100 + i));
          model_starve = 0;
        end else begin
          check("sv_no_ack", acks, acks0);
        end
      end else begin
        check("sv_stall_host_first", st, 2 * lat + 6);
        check("sv_ack_once", acks, acks0 + 1);
        check("sv_host_q", last_hq, ref_rd(32'h80100 + i));
        pop_check("sv_host_first", 32'h80100 + i, 1'b0, 2'b11, 0);
        pop_check("sv_cpu_second", a, 1'b0, 2'b11, 1);
        model_starve = 0;
      end
      check("sv_cpu_q", cpu_q, ref_rd(a));
      host_req = 1'b0;
      tick();
    end

    // Ready on the final allowed cycle still succeeds
    do_reset();
    lat = 63;
    cpu_access(32'h7, 16'h0, 2'b11, 0, 0, st);
    check("late_rdy_stall", st, 66);
    check("late_rdy_q", cpu_q, ref_rd(32'h7));
    check("late_rdy_err", err, 0);

    // No ready at all: abort, fill data, sticky error
    no_rdy = 1'b1;
    cpu_access(32'h8, 16'h0, 2'b11, 0, 0, st);
    check("to_stall", st, 66);
    check("to_cpu_q", cpu_q, 16'hFFFF);
    check("to_err", err, 1);
    check("to_wait_released", cpu_wait_n, 1);
    no_rdy = 1'b0;
    lat = 1;
    cpu_access(32'h9, 16'h0, 2'b11, 0, 0, st);
    check("to_next_q", cpu_q, ref_rd(32'h9));
    check("to_err_sticky", err, 1);
    do_reset();
    check("to_err_cleared", err, 0);

    // Reset two cycles into a host access; a late ready must do nothing
    lat = 20;
    host_we = 1'b0; host_a = AW'(32'h80020);
    acks0 = acks;
    host_req = 1'b1;
    st = 0;
    while (!mem_req && st < 20) begin
      st++;
      tick();
    end
    check("rm_req_seen", mem_req, 1);
    tick();
    rst = 1'b1;
    host_req = 1'b0;
    tick();
    check("rm_req_dropped", mem_req, 0);
    check("rm_wait_n", cpu_wait_n, 1);
    check("rm_no_ack_now", host_ack, 0);
    rst = 1'b0;
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rm_no_ack", acks, acks0);
    check("rm_req_idle", mem_req, 0);
    check("rm_host_q", host_q, 0);
    check("rm_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
